eth_gmii_tx: RTL

ETH_GMII_TX -- requirements
Module: eth_gmii_tx

---
 rtl/eth_pkg.sv | 35 +++
 rtl/eth_crc32_d8.sv | 36 +++
 rtl/eth_gmii_tx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the GMII frame transmitter.
// Holds the transmit state enum, framing bytes, buffer sizing and the CRC-32 byte-step function.
package eth_pkg;

  localparam int BUF_AW       = 11;
  localparam int BUF_DEPTH    = 1 << BUF_AW;
  localparam int PREAMBLE_LEN = 7;
  localparam int FCS_LEN      = 4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  // One byte of reflected CRC-32, LSB of the data byte entering first.
  function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Byte-serial Ethernet CRC-32 accumulator: one data byte per enabled cycle.
// crc_o is the raw register; the transmitter complements it when emitting the FCS.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC32_INIT;
    end else if (en_i) begin
      crc_d = crc32_d8_next(crc_q, data_i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_gmii_tx.sv
// GMII frame transmitter: preamble, SFD, buffered payload, zero pad, optional FCS, then IFG.
// Define ETH_TX_CRC_EN to append the 4-byte CRC-32 FCS; without it the frame ends after DATA/PAD.
module eth_gmii_tx
  import eth_pkg::*;
#(
  parameter int MIN_LEN   = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [BUF_AW-1:0] tx_len,
  input  logic              tx_start,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              gmii_tx_en,
  output logic [7:0]        gmii_tx_data
);

  localparam logic [BUF_AW-1:0] MIN_LEN_W = BUF_AW'(MIN_LEN);
  localparam logic [BUF_AW-1:0] PRE_LAST  = BUF_AW'(PREAMBLE_LEN - 1);
  localparam logic [BUF_AW-1:0] FCS_LAST  = BUF_AW'(FCS_LEN - 1);
  localparam logic [BUF_AW-1:0] IFG_LAST  = BUF_AW'(IFG_BYTES - 1);
  localparam tx_state_t         TAIL_STATE = (IFG_BYTES == 0) ? IDLE : IFG;
`ifdef ETH_TX_CRC_EN
  localparam tx_state_t         BODY_NEXT  = FCS;
`else
  localparam tx_state_t         BODY_NEXT  = TAIL_STATE;
`endif

  tx_state_t         state_q, state_d;
  logic [BUF_AW-1:0] cnt_q, cnt_d;
  logic [BUF_AW-1:0] len_q, len_d;
  logic [BUF_AW-1:0] rd_addr_q, rd_addr_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tx_done_q, tx_done_d;
  logic              gmii_en_q, gmii_en_d;
  logic [7:0]        gmii_data_q, gmii_data_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [BUF_DEPTH];

  // NOTE: the buffer and its read register carry no reset so they map onto block RAM;
  // contents therefore survive rst by construction.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr_q];
  end

`ifdef ETH_TX_CRC_EN
  logic [31:0] crc_value;
  logic        crc_init;
  logic        crc_en;

  assign crc_init = (state_q == IDLE) && (state_d == PRE);
  assign crc_en   = (state_d == DATA) || (state_d == PAD);

  eth_crc32_d8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (gmii_data_d),
    .crc_o  (crc_value)
  );
`endif

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    len_d     = len_q;
    rd_addr_d = rd_addr_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_start && (tx_len != '0)) begin
          state_d   = PRE;
          len_d     = tx_len;
          rd_addr_d = '0;
        end
      end
      PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d = SFD;
          cnt_d   = '0;
        end
      end
      SFD: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        // PAD keeps counting from len so it ends at MIN_LEN-1.
        if (cnt_q == len_q - 1'b1) begin
          if (len_q < MIN_LEN_W) begin
            state_d = PAD;
          end else begin
            state_d = BODY_NEXT;
            cnt_d   = '0;
          end
        end
      end
      PAD: begin
        if (cnt_q == MIN_LEN_W - 1'b1) begin
          state_d = BODY_NEXT;
          cnt_d   = '0;
        end
      end
      FCS: begin
        if (cnt_q == FCS_LAST) begin
          state_d = TAIL_STATE;
          cnt_d   = '0;
        end
      end
      IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Address runs two cycles ahead of the wire: register stage in the RAM plus the output flop.
    if (((state_q == PRE) && (cnt_q == PRE_LAST)) || (state_q == SFD) || (state_q == DATA)) begin
      rd_addr_d = rd_addr_q + 1'b1;
    end

    gmii_en_d   = 1'b0;
    gmii_data_d = 8'h00;
    case (state_d)
      PRE: begin
        gmii_en_d   = 1'b1;
        gmii_data_d = PREAMBLE_BYTE;
      end
      SFD: begin
        gmii_en_d   = 1'b1;
        gmii_data_d = SFD_BYTE;
      end
      DATA: begin
        gmii_en_d   = 1'b1;
        gmii_data_d = rd_data_q;
      end
      PAD: begin
        gmii_en_d   = 1'b1;
      end
`ifdef ETH_TX_CRC_EN
      FCS: begin
        gmii_en_d   = 1'b1;
        gmii_data_d = ~crc_value[{cnt_d[1:0], 3'b000} +: 8];
      end
`endif
      default: begin
        gmii_en_d   = 1'b0;
        gmii_data_d = 8'h00;
      end
    endcase

    tx_busy_d = (state_d != IDLE);
    tx_done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      rd_addr_q   <= '0;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      gmii_en_q   <= 1'b0;
      gmii_data_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
      gmii_en_q   <= gmii_en_d;
      gmii_data_q <= gmii_data_d;
    end
  end

  assign tx_busy      = tx_busy_q;
  assign tx_done      = tx_done_q;
  assign gmii_tx_en   = gmii_en_q;
  assign gmii_tx_data = gmii_data_q;

endmodule
